// File: rtl/float_post_normalizer.sv
// Post-normalize, round-to-nearest-even and pack stage of the single-precision adder.
// Takes the raw mantissa sum and its exponent, and handles one operation at a time over valid/ready.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand
// NORM  | one normalization step per cycle (right on carry, left on cancellation)
// ROUND | apply RNE increment, pack result, capture flags
// DONE  | out_valid high, result held until out_ready
module float_post_normalizer #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic [EXP_W-1:0]          in_exp,
    input  logic [FRAC_W+3:0]         in_mant,
    input  logic                      in_sticky,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     out_result,
    output logic                      out_overflow,
    output logic                      out_inexact,
    output logic                      out_zero
);

    localparam int MW = FRAC_W + 4;
    localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t          state, state_nx;
    logic            sign_r;
    logic [EXP_W:0]  exp_r;
    logic [MW-1:0]   mant_r;
    logic            sticky_r;

    logic            norm_done;
    logic            guard, rnd, lsb, inc;
    logic [FRAC_W+1:0] sig_sum;
    logic [FRAC_W:0] sig_n;
    logic [EXP_W:0]  exp_n;
    logic [EXP_W-1:0] exp_field;
    logic            zero_c, ovf_c, inexact_c;
    logic [EXP_W+FRAC_W:0] result_c;

    // A carry, a set hidden bit, a zero mantissa or a denormal exponent all end normalization.
    assign norm_done = (mant_r == '0) || mant_r[MW-1] || mant_r[MW-2] || (exp_r <= EXP_ONE);

    always_comb begin
        guard   = mant_r[1];
        rnd     = mant_r[0];
        lsb     = mant_r[2];
        inc     = guard & (rnd | sticky_r | lsb);
        sig_sum = {1'b0, mant_r[MW-2:2]} + {{(FRAC_W+1){1'b0}}, inc};
        if (sig_sum[FRAC_W+1]) begin
            sig_n = sig_sum[FRAC_W+1:1];
            exp_n = exp_r + EXP_ONE;
        end else begin
            sig_n = sig_sum[FRAC_W:0];
            exp_n = exp_r;
        end
        // Denormals pack with a zero exponent field unless rounding promoted them into the hidden bit.
        exp_field = sig_n[FRAC_W] ? exp_n[EXP_W-1:0] : '0;
        zero_c    = (mant_r == '0);
        ovf_c     = !zero_c && (exp_n >= EXP_MAX);
        inexact_c = !zero_c && (guard | rnd | sticky_r);
        if (zero_c)
            result_c = {sign_r, {(EXP_W+FRAC_W){1'b0}}};
        else if (ovf_c)
            result_c = {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        else
            result_c = {sign_r, exp_field, sig_n[FRAC_W-1:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = NORM;
            NORM:    if (norm_done) state_nx = ROUND;
            ROUND:   state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_r       <= 1'b0;
            exp_r        <= '0;
            mant_r       <= '0;
            sticky_r     <= 1'b0;
            out_result   <= '0;
            out_overflow <= 1'b0;
            out_inexact  <= 1'b0;
            out_zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign_r   <= in_sign;
                    exp_r    <= (in_exp == '0) ? EXP_ONE : {1'b0, in_exp};
                    mant_r   <= in_mant;
                    sticky_r <= in_sticky;
                end
                NORM: begin
                    if (!norm_done) begin
                        mant_r <= {mant_r[MW-2:0], 1'b0};
                        exp_r  <= exp_r - EXP_ONE;
                    end else if (mant_r[MW-1]) begin
                        mant_r   <= {1'b0, mant_r[MW-1:1]};
                        sticky_r <= sticky_r | mant_r[0];
                        exp_r    <= exp_r + EXP_ONE;
                    end
                end
                ROUND: begin
                    out_result   <= result_c;
                    out_overflow <= ovf_c;
                    out_inexact  <= inexact_c;
                    out_zero     <= zero_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_post_normalizer.sv
// Directed bench for float_post_normalizer: hand-computed packed results, flags and latency.
module tb_float_post_normalizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [26:0] in_mant = '0;
    logic        in_sticky = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_overflow, out_inexact, out_zero;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    float_post_normalizer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_sticky(in_sticky),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_overflow(out_overflow),
        .out_inexact(out_inexact), .out_zero(out_zero)
    );

    // Presents one operand, then counts edges from the accept edge until out_valid (-1 on timeout).
    task automatic issue(input logic s, input logic [7:0] e, input logic [26:0] m,
                         input logic st, output int lat);
        @(negedge clk);
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m; in_sticky = st;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sign = ~s; in_exp = 8'($urandom); in_mant = 27'($urandom); in_sticky = ~st;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++; $display("FAIL reset_handshake got %b want 10", {in_ready, out_valid});
        end
        vectors++;
        if ({out_result, out_overflow, out_inexact, out_zero} !== 35'h0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", {out_result, out_overflow, out_inexact, out_zero});
        end
    endtask

    task automatic test_normalized();
        int lat;
        issue(1'b0, 8'd127, 27'h2000000, 1'b0, lat);
        vectors++;
        if (lat !== 3) begin errors++; $display("FAIL norm_latency got %0d want 3", lat); end
        vectors++;
        if ({out_result, out_overflow, out_inexact, out_zero} !== {32'h3F800000, 3'b000}) begin
            errors++; $display("FAIL norm_result got %h/%b want 3f800000/000", out_result, {out_overflow, out_inexact, out_zero});
        end
        release_out();
    endtask

    task automatic test_carry();
        int lat;
        issue(1'b0, 8'd127, 27'h4000000, 1'b0, lat);
        vectors++;
        if (lat !== 3) begin errors++; $display("FAIL carry_latency got %0d want 3", lat); end
        vectors++;
        if ({out_result, out_inexact} !== {32'h40000000, 1'b0}) begin
            errors++; $display("FAIL carry_result got %h/%b want 40000000/0", out_result, out_inexact);
        end
        release_out();
        issue(1'b0, 8'd127, 27'h4000001, 1'b0, lat);
        vectors++;
        if ({out_result, out_overflow, out_inexact, out_zero} !== {32'h40000000, 3'b010}) begin
            errors++; $display("FAIL carry_sticky got %h/%b want 40000000/010", out_result, {out_overflow, out_inexact, out_zero});
        end
        release_out();
    endtask

    task automatic test_left_shift();
        int lat;
        issue(1'b0, 8'd130, 27'h0800000, 1'b0, lat);
        vectors++;
        if (lat !== 5) begin errors++; $display("FAIL lshift_latency got %0d want 5", lat); end
        vectors++;
        if (out_result !== 32'h40000000) begin
            errors++; $display("FAIL lshift_result got %h want 40000000", out_result);
        end
        release_out();
    endtask

    task automatic test_tie_even();
        int lat;
        issue(1'b0, 8'd127, 27'h2000006, 1'b0, lat);
        vectors++;
        if ({out_result, out_inexact} !== {32'h3F800002, 1'b1}) begin
            errors++; $display("FAIL tie_odd got %h/%b want 3f800002/1", out_result, out_inexact);
        end
        release_out();
        issue(1'b0, 8'd127, 27'h2000002, 1'b0, lat);
        vectors++;
        if ({out_result, out_inexact} !== {32'h3F800000, 1'b1}) begin
            errors++; $display("FAIL tie_even got %h/%b want 3f800000/1", out_result, out_inexact);
        end
        release_out();
        issue(1'b0, 8'd127, 27'h2000002, 1'b1, lat);
        vectors++;
        if ({out_result, out_inexact} !== {32'h3F800001, 1'b1}) begin
            errors++; $display("FAIL tie_sticky got %h/%b want 3f800001/1", out_result, out_inexact);
        end
        release_out();
    endtask

    task automatic test_denormal();
        int lat;
        issue(1'b0, 8'd0, 27'h1000000, 1'b0, lat);
        vectors++;
        if (lat !== 3) begin errors++; $display("FAIL denorm_latency got %0d want 3", lat); end
        vectors++;
        if ({out_result, out_overflow, out_inexact, out_zero} !== {32'h00400000, 3'b000}) begin
            errors++; $display("FAIL denorm_result got %h/%b want 00400000/000", out_result, {out_overflow, out_inexact, out_zero});
        end
        release_out();
        issue(1'b0, 8'd1, 27'h1FFFFFE, 1'b0, lat);
        vectors++;
        if ({out_result, out_inexact} !== {32'h00800000, 1'b1}) begin
            errors++; $display("FAIL denorm_promote got %h/%b want 00800000/1", out_result, out_inexact);
        end
        release_out();
    endtask

    task automatic test_overflow_zero();
        int lat;
        issue(1'b1, 8'd254, 27'h4000000, 1'b0, lat);
        vectors++;
        if ({out_result, out_overflow, out_zero} !== {32'hFF800000, 2'b10}) begin
            errors++; $display("FAIL overflow got %h/%b want ff800000/10", out_result, {out_overflow, out_zero});
        end
        release_out();
        issue(1'b1, 8'd90, 27'h0000000, 1'b0, lat);
        vectors++;
        if (lat !== 3) begin errors++; $display("FAIL zero_latency got %0d want 3", lat); end
        vectors++;
        if ({out_result, out_overflow, out_inexact, out_zero} !== {32'h80000000, 3'b001}) begin
            errors++; $display("FAIL zero_result got %h/%b want 80000000/001", out_result, {out_overflow, out_inexact, out_zero});
        end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        issue(1'b0, 8'd130, 27'h0800000, 1'b0, lat);
        @(negedge clk);
        in_valid = 1'b1; in_exp = 8'd1; in_mant = 27'h0000001;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if ({out_valid, in_ready, out_result} !== {2'b10, 32'h40000000}) bad++;
        end
        in_valid = 1'b0;
        vectors++;
        if (bad !== 0) begin errors++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
        release_out();
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL release got %b want 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_reset_mid_norm();
        int lat;
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd100; in_mant = 27'h0000100; in_sticky = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        vectors++;
        if ({in_ready, out_valid} !== 2'b00) begin
            errors++; $display("FAIL in_norm got %b want 00", {in_ready, out_valid});
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, out_result} !== {2'b10, 32'h0}) begin
            errors++; $display("FAIL async_reset got %b/%h want 10/0", {in_ready, out_valid}, out_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 8'd127, 27'h2000000, 1'b0, lat);
        vectors++;
        if ({lat == 3, out_result} !== {1'b1, 32'h3F800000}) begin
            errors++; $display("FAIL post_reset got lat %0d res %h want 3/3f800000", lat, out_result);
        end
        release_out();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_normalized();
        test_carry();
        test_left_shift();
        test_tie_even();
        test_denormal();
        test_overflow_zero();
        test_backpressure();
        test_reset_mid_norm();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
